eth_stream_stats_monitor: RTL
=============================

Name: eth_stream_stats_monitor

Overview:
Synthesisable multi-channel Ethernet packet-mode stream monitor that counts packets, bytes and active cycles per channel and checks SoP/EoP framing. It taps NUM_CH NAP Ethernet streams passively and never drives ready. It supports manual or automatic start and a stop-on-count mode. Results are held after stop and read back per channel through a registered read port for a host or JTAG register bridge.

Parameters:
NUM_CH, 8, number of monitored streams
DATA_WIDTH, 1024, stream data width in bits; BYTE_WIDTH = DATA_WIDTH/8, MOD_WIDTH = $clog2(BYTE_WIDTH)
CNT_WIDTH, 48, width of packet, byte and cycle counters
ERR_WIDTH, 16, width of error counters
STOP_COUNT, 0, non-zero: a channel freezes after this many packets; run ends when all enabled channels reach it; i_stop ignored
AUTO_START, 0, non-zero: run starts on the first valid SoP on any enabled channel; i_start ignored

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_start  in  1  start run (level, sampled in IDLE)
i_stop  in  1  end run (sampled in RUN)
i_clear  in  1  clear all statistics, return to IDLE
i_enable  in  NUM_CH  per-channel monitor enable
i_valid  in  NUM_CH  stream valid
i_ready  in  NUM_CH  stream ready (observed only)
i_sop  in  NUM_CH  start of packet
i_eop  in  NUM_CH  end of packet
i_mod  in  NUM_CH*MOD_WIDTH  valid bytes on EoP beat; 0 = full beat
i_rd_req  in  1  read request
i_rd_ch  in  8  channel to read
o_rd_valid  out  1  read data valid
o_rd_pkt  out  CNT_WIDTH  packet count of the selected channel
o_rd_bytes  out  CNT_WIDTH  byte count of the selected channel
o_rd_err  out  ERR_WIDTH  framing error count of the selected channel
o_cycles  out  CNT_WIDTH  cycles spent counting (global)
o_active  out  1  state == RUN
o_done  out  1  state == DONE
o_err_flag  out  NUM_CH  sticky per-channel framing error

Behaviour:
- Reset (async): state IDLE; all counters, frame flags and outputs are 0.
- Transfer on channel c: xfer[c] = i_valid[c] & i_ready[c] & i_enable[c].
- FSM IDLE->RUN: i_start, or with AUTO_START, any xfer & i_sop. RUN->DONE: i_stop, or with STOP_COUNT, every enabled channel has pkt == STOP_COUNT. Any state->IDLE: i_clear, which has priority over all other inputs and zeroes counters, frame flags and o_err_flag. DONE holds until i_clear.
- count_en = (state==RUN) | start_fire. The triggering beat of the start cycle is counted. Beats on the i_stop cycle are counted. Counting stops from the following cycle.
- With STOP_COUNT set, a channel whose pkt == STOP_COUNT ignores further beats.
- o_cycles increments every cycle count_en is high.
- Per xfer while count_en: bytes += eop ? (mod==0 ? BYTE_WIDTH : mod) : BYTE_WIDTH; pkt += eop.
- Framing per channel, with in_frame flag:
  - SoP while in_frame is an error.
  - EoP while !in_frame and !SoP is an error.
  - SoP&EoP while !in_frame is a legal single-beat frame.
  - Next in_frame = eop ? 0 : (sop ? 1 : in_frame).
  - Each error increments err and sets o_err_flag[c].
- All counters saturate at all-ones and never wrap.
- Read port: o_rd_* and o_rd_valid are registered one cycle after i_rd_req. i_rd_ch >= NUM_CH returns zeros with o_rd_valid=1. Reads are legal in any state; in RUN they return live values.
- Disabled channels do not count, do not check framing and are excluded from the STOP_COUNT completion test.
- i_start in RUN/DONE is ignored. i_stop in IDLE is ignored.

Test Plan:
- DATA_WIDTH=1024, ch0 enabled, i_start, 3 packets of 2 beats each with EoP mod=64, then i_stop -> read ch0 one cycle later: pkt=3, bytes=576, err=0; o_done=1.
- Same traffic with i_ready low on alternate beats (valid held) -> pkt=3, bytes=576; o_cycles equals the cycles from start to stop inclusive.
- ch1: EoP with no open frame, then SoP, SoP, EoP -> err=2, o_err_flag[1]=1, pkt=2; a single-beat SoP&EoP with mod=0 adds 128 bytes and no error.
- STOP_COUNT=4, AUTO_START=1, ch0 and ch2 enabled; ch0 sends 6 packets, ch2 sends 4 -> run starts on the first SoP and counts that beat; ch0 pkt=4; DONE when ch2 reaches 4.
- Assert i_reset_n low mid-frame in RUN -> all outputs 0 asynchronously, state IDLE; the next SoP after restart raises no error.
- Apply i_clear in DONE, then i_rd_ch=9 -> IDLE, counters 0; o_rd_valid=1 with all data 0.

Source files
------------

// File: rtl/eth_stream_stats_monitor.sv
// Passive per-channel packet/byte/framing-error monitor over NUM_CH Ethernet streams with a global cycle counter.
// Read data is registered one cycle after i_rd_req; the taps only observe valid/ready and never apply backpressure.
module eth_stream_stats_monitor #(
  parameter int NUM_CH      = 8,
  parameter int DATA_WIDTH  = 1024,
  parameter int CNT_WIDTH   = 48,
  parameter int ERR_WIDTH   = 16,
  parameter int STOP_COUNT  = 0,
  parameter int AUTO_START  = 0,
  localparam int BYTE_WIDTH = DATA_WIDTH / 8,
  localparam int MOD_WIDTH  = $clog2(BYTE_WIDTH)
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  input  logic                        i_stop,
  input  logic                        i_clear,
  input  logic [NUM_CH-1:0]           i_enable,
  input  logic [NUM_CH-1:0]           i_valid,
  input  logic [NUM_CH-1:0]           i_ready,
  input  logic [NUM_CH-1:0]           i_sop,
  input  logic [NUM_CH-1:0]           i_eop,
  input  logic [NUM_CH*MOD_WIDTH-1:0] i_mod,
  input  logic                        i_rd_req,
  input  logic [7:0]                  i_rd_ch,
  output logic                        o_rd_valid,
  output logic [CNT_WIDTH-1:0]        o_rd_pkt,
  output logic [CNT_WIDTH-1:0]        o_rd_bytes,
  output logic [ERR_WIDTH-1:0]        o_rd_err,
  output logic [CNT_WIDTH-1:0]        o_cycles,
  output logic                        o_active,
  output logic                        o_done,
  output logic [NUM_CH-1:0]           o_err_flag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam bit                   STOP_EN   = (STOP_COUNT != 0);
  localparam logic [CNT_WIDTH-1:0] STOP_VAL  = CNT_WIDTH'(STOP_COUNT);
  localparam logic [CNT_WIDTH-1:0] FULL_BEAT = CNT_WIDTH'(BYTE_WIDTH);

  state_e state_q, state_d;

  logic [CNT_WIDTH-1:0] pkt_q   [NUM_CH];
  logic [CNT_WIDTH-1:0] pkt_d   [NUM_CH];
  logic [CNT_WIDTH-1:0] bytes_q [NUM_CH];
  logic [CNT_WIDTH-1:0] bytes_d [NUM_CH];
  logic [ERR_WIDTH-1:0] err_q   [NUM_CH];
  logic [ERR_WIDTH-1:0] err_d   [NUM_CH];
  logic [NUM_CH-1:0]    in_frame_q, in_frame_d;
  logic [NUM_CH-1:0]    err_flag_q, err_flag_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;

  logic                 rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0] rd_pkt_q, rd_pkt_d;
  logic [CNT_WIDTH-1:0] rd_bytes_q, rd_bytes_d;
  logic [ERR_WIDTH-1:0] rd_err_q, rd_err_d;

  logic [NUM_CH-1:0]    xfer, sop_xfer, frozen, act, frame_err;
  logic [CNT_WIDTH-1:0] beat_bytes [NUM_CH];
  logic                 start_cond, start_fire, stop_cond, count_en, all_done;

  function automatic logic [CNT_WIDTH-1:0] sat_add_cnt(input logic [CNT_WIDTH-1:0] a,
                                                       input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [ERR_WIDTH-1:0] sat_inc_err(input logic [ERR_WIDTH-1:0] a);
    return (&a) ? a : a + ERR_WIDTH'(1);
  endfunction

  // Beat qualification, run triggers and per-channel freeze / completion status.
  always_comb begin
    xfer       = i_valid & i_ready & i_enable;
    sop_xfer   = xfer & i_sop;
    start_cond = (AUTO_START != 0) ? |sop_xfer : i_start;
    start_fire = (state_q == ST_IDLE) && start_cond && !i_clear;
    count_en   = !i_clear && ((state_q == ST_RUN) || start_fire);
    frozen     = '0;
    act        = '0;
    frame_err  = '0;
    all_done   = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      frozen[c]     = STOP_EN && (pkt_q[c] == STOP_VAL);
      act[c]        = count_en && xfer[c] && !frozen[c];
      frame_err[c]  = (i_sop[c] && in_frame_q[c]) || (i_eop[c] && !in_frame_q[c] && !i_sop[c]);
      beat_bytes[c] = (i_eop[c] && (i_mod[c*MOD_WIDTH +: MOD_WIDTH] != '0))
                      ? CNT_WIDTH'(i_mod[c*MOD_WIDTH +: MOD_WIDTH]) : FULL_BEAT;
      if (i_enable[c] && (pkt_q[c] != STOP_VAL)) begin
        all_done = 1'b0;
      end
    end
    stop_cond = STOP_EN ? all_done : i_stop;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_cond) state_d = ST_RUN;
      ST_RUN:  if (stop_cond)  state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (i_clear) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    o_active = (state_q == ST_RUN);
    o_done   = (state_q == ST_DONE);
  end

  // Statistics update; clear wins over any beat in the same cycle.
  always_comb begin
    cycles_d   = cycles_q;
    in_frame_d = in_frame_q;
    err_flag_d = err_flag_q;
    for (int c = 0; c < NUM_CH; c++) begin
      pkt_d[c]   = pkt_q[c];
      bytes_d[c] = bytes_q[c];
      err_d[c]   = err_q[c];
    end
    if (i_clear) begin
      cycles_d   = '0;
      in_frame_d = '0;
      err_flag_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pkt_d[c]   = '0;
        bytes_d[c] = '0;
        err_d[c]   = '0;
      end
    end else begin
      if (count_en) begin
        cycles_d = sat_add_cnt(cycles_q, CNT_WIDTH'(1));
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (act[c]) begin
          bytes_d[c] = sat_add_cnt(bytes_q[c], beat_bytes[c]);
          if (i_eop[c]) begin
            pkt_d[c] = sat_add_cnt(pkt_q[c], CNT_WIDTH'(1));
          end
          if (frame_err[c]) begin
            err_d[c]      = sat_inc_err(err_q[c]);
            err_flag_d[c] = 1'b1;
          end
          in_frame_d[c] = i_eop[c] ? 1'b0 : (i_sop[c] ? 1'b1 : in_frame_q[c]);
        end
      end
    end
  end

  // Read port samples the live (pre-update) counters; out-of-range channels read as zero.
  always_comb begin
    rd_valid_d = i_rd_req;
    rd_pkt_d   = rd_pkt_q;
    rd_bytes_d = rd_bytes_q;
    rd_err_d   = rd_err_q;
    if (i_rd_req) begin
      rd_pkt_d   = '0;
      rd_bytes_d = '0;
      rd_err_d   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (int'(i_rd_ch) == c) begin
          rd_pkt_d   = pkt_q[c];
          rd_bytes_d = bytes_q[c];
          rd_err_d   = err_q[c];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cycles_q   <= '0;
      in_frame_q <= '0;
      err_flag_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pkt_q[c]   <= '0;
        bytes_q[c] <= '0;
        err_q[c]   <= '0;
      end
      rd_valid_q <= 1'b0;
      rd_pkt_q   <= '0;
      rd_bytes_q <= '0;
      rd_err_q   <= '0;
    end else begin
      cycles_q   <= cycles_d;
      in_frame_q <= in_frame_d;
      err_flag_q <= err_flag_d;
      for (int c = 0; c < NUM_CH; c++) begin
        pkt_q[c]   <= pkt_d[c];
        bytes_q[c] <= bytes_d[c];
        err_q[c]   <= err_d[c];
      end
      rd_valid_q <= rd_valid_d;
      rd_pkt_q   <= rd_pkt_d;
      rd_bytes_q <= rd_bytes_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_pkt   = rd_pkt_q;
  assign o_rd_bytes = rd_bytes_q;
  assign o_rd_err   = rd_err_q;
  assign o_cycles   = cycles_q;
  assign o_err_flag = err_flag_q;

endmodule
